conv_1x1_layer_sequencer: RTL and testbench

- Controls one 1x1 convolution layer: conv loop-data stage → conv_1x1_top_new → channel adder.
- Per start command it:
  - preloads the layer weights from an external weight memory onto the weight port,
  - gates the pixel stream into the loop-data stage,
  - counts adder outputs until the layer is complete, then pulses done.
- Lets the top level run layers back to back without hand-sequencing weight and pixel phases.

---
 rtl/conv_1x1_layer_sequencer_pkg.sv | 33 +++
 rtl/conv_seq_counter.sv | 28 ++
 rtl/conv_1x1_layer_sequencer.sv | 145 ++++++++++++++
 tb/tb_conv_1x1_layer_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_1x1_layer_sequencer_pkg.sv
// Shared definitions for conv_1x1_layer_sequencer: FSM encoding, derived layer counts
// and counter sizing.
package conv_1x1_layer_sequencer_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LOAD_W   = 3'd1;
  localparam logic [2:0] ST_DRAIN_W  = 3'd2;
  localparam logic [2:0] ST_STREAM   = 3'd3;
  localparam logic [2:0] ST_WAIT_OUT = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

  function automatic int unsigned calc_nw(input int unsigned cin, input int unsigned cout);
    return cin * cout;
  endfunction

  function automatic int unsigned calc_np(input int unsigned w, input int unsigned h,
                                          input int unsigned cin);
    return w * h * cin;
  endfunction

  function automatic int unsigned calc_no(input int unsigned w, input int unsigned h,
                                          input int unsigned cout, input logic s2);
    return s2 ? cout * (w / 2) * (h / 2) : cout * w * h;
  endfunction

  // Widens a counter when the requested width cannot hold its terminal count.
  function automatic int unsigned cnt_bits(input int unsigned n, input int unsigned w);
    int unsigned need;
    need = $clog2(n + 1);
    return (need > w) ? need : w;
  endfunction

endpackage

// File: rtl/conv_seq_counter.sv
// Loadable up-counter with a terminal-count flag (count == i_term).
module conv_seq_counter
  import conv_1x1_layer_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_term,
  output logic [WIDTH-1:0] o_count,
  output logic             o_tc
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!reset)      r_count <= '0;
    else if (i_load) r_count <= i_load_val;
    else if (i_en)   r_count <= r_count + 1'b1;
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == i_term);

endmodule

// File: rtl/conv_1x1_layer_sequencer.sv
// Sequences one 1x1 conv layer: weight preload, gated pixel stream, output counting.
// Optional watchdog enabled by defining SEQ_TIMEOUT_EN.
module conv_1x1_layer_sequencer
  import conv_1x1_layer_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned IMAGE_WIDTH     = 306,
  parameter int unsigned IMAGE_HEIGHT    = 306,
  parameter int unsigned CHANNEL_NUM_IN  = 64,
  parameter int unsigned CHANNEL_NUM_OUT = 256,
  parameter int unsigned WADDR_WIDTH     = 15,
  parameter int unsigned CNT_WIDTH       = 24,
  parameter int unsigned TIMEOUT_CYCLES  = 65535
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stride2_cfg,
  output logic                   weight_rd_en,
  output logic [WADDR_WIDTH-1:0] weight_rd_addr,
  input  logic [DATA_WIDTH-1:0]  weight_rd_data,
  output logic                   valid_weight_out,
  output logic [DATA_WIDTH-1:0]  weight_out,
  output logic                   stride2,
  input  logic                   valid_pxl_in,
  input  logic [DATA_WIDTH-1:0]  pxl_in,
  output logic                   pxl_ready,
  output logic                   valid_pxl_out,
  output logic [DATA_WIDTH-1:0]  pxl_out,
  input  logic                   conv_valid_out,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  localparam int unsigned NW     = calc_nw(CHANNEL_NUM_IN, CHANNEL_NUM_OUT);
  localparam int unsigned NP     = calc_np(IMAGE_WIDTH, IMAGE_HEIGHT, CHANNEL_NUM_IN);
  localparam int unsigned NO_S1  = calc_no(IMAGE_WIDTH, IMAGE_HEIGHT, CHANNEL_NUM_OUT, 1'b0);
  localparam int unsigned NO_S2  = calc_no(IMAGE_WIDTH, IMAGE_HEIGHT, CHANNEL_NUM_OUT, 1'b1);
  localparam int unsigned PCNT_W = cnt_bits(NP, CNT_WIDTH);
  localparam int unsigned OCNT_W = cnt_bits((NO_S1 > NO_S2) ? NO_S1 : NO_S2, CNT_WIDTH);

  if ((TIMEOUT_CYCLES == 0) || (64'(NW) > (64'd1 << WADDR_WIDTH))) begin : g_cfg_check
    $error("conv_1x1_layer_sequencer: TIMEOUT_CYCLES must be >= 1 and WADDR_WIDTH must cover NW");
  end

  logic [2:0]             r_state, w_state_next;
  logic                   r_stride2, r_valid_w, r_valid_pxl;
  logic [DATA_WIDTH-1:0]  r_pxl;
  logic                   w_start_ok, w_xfer, w_pxl_last, w_active, w_out_en, w_out_hit, w_timeout;
  logic [WADDR_WIDTH-1:0] w_waddr;
  logic                   w_waddr_tc, w_pcnt_tc, w_ocnt_tc;
  logic [PCNT_W-1:0]      w_pcnt;
  logic [OCNT_W-1:0]      w_ocnt, w_no;

  assign w_start_ok = (r_state == ST_IDLE) && start;
  assign w_active   = (r_state == ST_STREAM) || (r_state == ST_WAIT_OUT);
  assign w_xfer     = valid_pxl_in && pxl_ready;
  assign w_pxl_last = w_xfer && (w_pcnt == PCNT_W'(NP - 1));
  assign w_no       = r_stride2 ? OCNT_W'(NO_S2) : OCNT_W'(NO_S1);
  assign w_out_en   = conv_valid_out && w_active && !w_ocnt_tc;
  // Look ahead one output so done follows the final conv_valid_out by a single cycle.
  assign w_out_hit  = w_ocnt_tc || (w_out_en && (w_ocnt == w_no - 1'b1));

  conv_seq_counter #(.WIDTH(WADDR_WIDTH)) u_waddr_cnt (
    .clk(clk), .reset(reset), .i_load(w_start_ok), .i_load_val('0),
    .i_en(r_state == ST_LOAD_W), .i_term(WADDR_WIDTH'(NW - 1)),
    .o_count(w_waddr), .o_tc(w_waddr_tc)
  );

  conv_seq_counter #(.WIDTH(PCNT_W)) u_pxl_cnt (
    .clk(clk), .reset(reset), .i_load(w_start_ok), .i_load_val('0),
    .i_en(w_xfer), .i_term(PCNT_W'(NP)),
    .o_count(w_pcnt), .o_tc(w_pcnt_tc)
  );

  conv_seq_counter #(.WIDTH(OCNT_W)) u_out_cnt (
    .clk(clk), .reset(reset), .i_load(w_start_ok), .i_load_val('0),
    .i_en(w_out_en), .i_term(w_no),
    .o_count(w_ocnt), .o_tc(w_ocnt_tc)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:     if (start) w_state_next = ST_LOAD_W;
      ST_LOAD_W:   if (w_waddr_tc) w_state_next = ST_DRAIN_W;
      ST_DRAIN_W:  w_state_next = ST_STREAM;
      ST_STREAM:   if (w_pxl_last) w_state_next = ST_WAIT_OUT;
      ST_WAIT_OUT: if (w_out_hit) w_state_next = ST_DONE;
      ST_DONE:     w_state_next = ST_IDLE;
      default:     w_state_next = ST_IDLE;
    endcase
    if (w_timeout) w_state_next = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_stride2   <= 1'b0;
      r_valid_w   <= 1'b0;
      r_valid_pxl <= 1'b0;
      r_pxl       <= '0;
    end else begin
      r_state     <= w_state_next;
      if (w_start_ok) r_stride2 <= stride2_cfg;
      r_valid_w   <= weight_rd_en;
      r_valid_pxl <= w_xfer;
      if (w_xfer) r_pxl <= pxl_in;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDOG_W-1:0] r_wdog;
  logic              r_error;

  assign w_timeout = w_active && !w_xfer && !conv_valid_out &&
                     (r_wdog == WDOG_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset || !w_active || w_xfer || conv_valid_out || w_timeout) r_wdog <= '0;
    else r_wdog <= r_wdog + 1'b1;
    if (!reset) r_error <= 1'b0;
    else        r_error <= w_timeout;
  end

  assign error = r_error;
`else
  assign w_timeout = 1'b0;
  assign error     = 1'b0;
`endif

  assign weight_rd_en     = (r_state == ST_LOAD_W);
  assign weight_rd_addr   = weight_rd_en ? w_waddr : '0;
  assign valid_weight_out = r_valid_w;
  assign weight_out       = r_valid_w ? weight_rd_data : '0;
  assign stride2          = r_stride2;
  assign pxl_ready        = (r_state == ST_STREAM) && !w_pcnt_tc;
  assign valid_pxl_out    = r_valid_pxl;
  assign pxl_out          = r_pxl;
  assign busy             = (r_state != ST_IDLE);
  assign done             = (r_state == ST_DONE);

endmodule

// File: tb/tb_conv_1x1_layer_sequencer.sv
// Directed bench for conv_1x1_layer_sequencer with a 4x4x2 -> 3 channel layer
// (NW=6, NP=32, NO=48 / 12); the watchdog scenario runs when SEQ_TIMEOUT_EN is defined.
module tb_conv_1x1_layer_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stride2_cfg = 1'b0;
  logic        weight_rd_en;
  logic [14:0] weight_rd_addr;
  logic [31:0] weight_rd_data;
  logic        valid_weight_out;
  logic [31:0] weight_out;
  logic        stride2;
  logic        valid_pxl_in = 1'b0;
  logic [31:0] pxl_in = '0;
  logic        pxl_ready;
  logic        valid_pxl_out;
  logic [31:0] pxl_out;
  logic        conv_valid_out = 1'b0;
  logic        busy, done, error;

  int checks = 0;
  int errors = 0;

  conv_1x1_layer_sequencer #(
    .DATA_WIDTH(32), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4), .CHANNEL_NUM_IN(2),
    .CHANNEL_NUM_OUT(3), .WADDR_WIDTH(15), .CNT_WIDTH(24), .TIMEOUT_CYCLES(20)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stride2_cfg(stride2_cfg),
    .weight_rd_en(weight_rd_en), .weight_rd_addr(weight_rd_addr),
    .weight_rd_data(weight_rd_data), .valid_weight_out(valid_weight_out),
    .weight_out(weight_out), .stride2(stride2), .valid_pxl_in(valid_pxl_in),
    .pxl_in(pxl_in), .pxl_ready(pxl_ready), .valid_pxl_out(valid_pxl_out),
    .pxl_out(pxl_out), .conv_valid_out(conv_valid_out), .busy(busy), .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  // Weight memory: one-cycle read latency, word value equals its address.
  always @(posedge clk) begin
    if (!reset) weight_rd_data <= '0;
    else if (weight_rd_en) weight_rd_data <= 32'(weight_rd_addr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) tick();
    checks++;
    if ({busy, done, error, weight_rd_en, valid_weight_out, stride2, pxl_ready, valid_pxl_out} !== 8'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 00000000",
               {busy, done, error, weight_rd_en, valid_weight_out, stride2, pxl_ready, valid_pxl_out});
    end
    checks++;
    if (weight_rd_addr !== 15'd0 || weight_out !== 32'd0 || pxl_out !== 32'd0) begin
      errors++;
      $display("FAIL reset_data addr=%0d wout=%0h pout=%0h exp all 0", weight_rd_addr, weight_out, pxl_out);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_release busy=%b done=%b exp 0 0", busy, done);
    end
  endtask

  task automatic test_weight_load(input logic s2);
    stride2_cfg = s2;
    start = 1'b1;
    tick();
    start = 1'b0;
    stride2_cfg = ~s2;
    checks++;
    if (busy !== 1'b1 || weight_rd_en !== 1'b1 || weight_rd_addr !== 15'd0 || valid_weight_out !== 1'b0) begin
      errors++;
      $display("FAIL wl_first busy=%b rd_en=%b addr=%0d vw=%b exp 1 1 0 0",
               busy, weight_rd_en, weight_rd_addr, valid_weight_out);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (valid_weight_out !== 1'b1 || weight_out !== 32'(i) || pxl_ready !== 1'b0 ||
          weight_rd_en !== (i < 5) || stride2 !== s2) begin
        errors++;
        $display("FAIL wl_word[%0d] vw=%b w=%0d ready=%b rd_en=%b s2=%b exp 1 %0d 0 %b %b",
                 i, valid_weight_out, weight_out, pxl_ready, weight_rd_en, stride2, i, (i < 5), s2);
      end
    end
    tick();
    checks++;
    if (valid_weight_out !== 1'b0 || pxl_ready !== 1'b1) begin
      errors++;
      $display("FAIL wl_ready vw=%b ready=%b exp 0 1", valid_weight_out, pxl_ready);
    end
    stride2_cfg = 1'b0;
  endtask

  task automatic test_pixels(input logic toggle, input int n_conv);
    int          sent = 0;
    int          k = 0;
    logic        exp_x;
    logic [31:0] exp_d;
    while (sent < 32 && k < 200) begin
      valid_pxl_in   = toggle ? (k % 2 == 0) : 1'b1;
      pxl_in         = 32'hA500_0000 + 32'(sent);
      conv_valid_out = (k < n_conv);
      checks++;
      if (pxl_ready !== 1'b1) begin
        errors++;
        $display("FAIL px_ready k=%0d got %b exp 1", k, pxl_ready);
      end
      exp_x = valid_pxl_in;
      exp_d = pxl_in;
      tick();
      checks++;
      if (valid_pxl_out !== exp_x || (exp_x && pxl_out !== exp_d)) begin
        errors++;
        $display("FAIL px_out k=%0d valid=%b data=%0h exp %b %0h", k, valid_pxl_out, pxl_out, exp_x, exp_d);
      end
      if (exp_x) sent++;
      k++;
    end
    valid_pxl_in   = 1'b1;
    conv_valid_out = 1'b0;
    checks++;
    if (sent != 32 || pxl_ready !== 1'b0) begin
      errors++;
      $display("FAIL px_done sent=%0d ready=%b exp 32 0", sent, pxl_ready);
    end
    tick();
    checks++;
    if (valid_pxl_out !== 1'b0) begin
      errors++;
      $display("FAIL px_extra valid_pxl_out=%b exp 0", valid_pxl_out);
    end
    valid_pxl_in = 1'b0;
  endtask

  task automatic test_outputs(input int n_before);
    for (int j = 0; j < 48 - n_before - 1; j++) begin
      conv_valid_out = 1'b1;
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL out_early j=%0d done=%b busy=%b exp 0 1", j, done, busy);
      end
    end
    conv_valid_out = 1'b1;
    tick();
    conv_valid_out = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL out_done done=%b busy=%b exp 1 1", done, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL out_idle done=%b busy=%b error=%b exp 0 0 0", done, busy, error);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL out_once done=%b busy=%b exp 0 0", done, busy);
    end
  endtask

  task automatic test_stride2();
    test_weight_load(1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || pxl_ready !== 1'b1 || stride2 !== 1'b1) begin
      errors++;
      $display("FAIL s2_busy_start busy=%b ready=%b s2=%b exp 1 1 1", busy, pxl_ready, stride2);
    end
    test_pixels(1'b0, 14);
    checks++;
    if (done !== 1'b1 || stride2 !== 1'b1) begin
      errors++;
      $display("FAIL s2_done done=%b s2=%b exp 1 1", done, stride2);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL s2_idle done=%b busy=%b exp 0 0", done, busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || weight_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL s2_no_queue busy=%b rd_en=%b exp 0 0", busy, weight_rd_en);
    end
  endtask

  task automatic test_reset_mid();
    test_weight_load(1'b1);
    for (int i = 0; i < 5; i++) begin
      valid_pxl_in = 1'b1;
      pxl_in = 32'h0000_C000 + 32'(i);
      tick();
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({busy, done, error, weight_rd_en, valid_weight_out, stride2, pxl_ready, valid_pxl_out} !== 8'b0) begin
      errors++;
      $display("FAIL rst_mid got %b exp 00000000",
               {busy, done, error, weight_rd_en, valid_weight_out, stride2, pxl_ready, valid_pxl_out});
    end
    checks++;
    if (pxl_out !== 32'd0) begin
      errors++;
      $display("FAIL rst_mid_data pxl_out=%0h exp 0", pxl_out);
    end
    reset = 1'b1;
    valid_pxl_in = 1'b0;
    repeat (2) tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle busy=%b done=%b exp 0 0", busy, done);
    end
    test_weight_load(1'b0);
    test_pixels(1'b1, 10);
    test_outputs(10);
  endtask

`ifdef SEQ_TIMEOUT_EN
  task automatic test_timeout();
    test_weight_load(1'b0);
    test_pixels(1'b0, 32);
    for (int i = 0; i < 8; i++) begin
      conv_valid_out = 1'b1;
      tick();
    end
    conv_valid_out = 1'b0;
    for (int t = 1; t < 20; t++) begin
      tick();
      checks++;
      if (error !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL to_early t=%0d error=%b busy=%b exp 0 1", t, error, busy);
      end
    end
    tick();
    checks++;
    if (error !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL to_error error=%b done=%b busy=%b exp 1 0 0", error, done, busy);
    end
    tick();
    checks++;
    if (error !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL to_idle error=%b done=%b busy=%b exp 0 0 0", error, done, busy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_weight_load(1'b0);
    test_pixels(1'b1, 10);
    test_outputs(10);
    test_stride2();
    test_reset_mid();
`ifdef SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout time=%0t limit=200000", $time);
    $fatal(1);
  end

endmodule
